// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : irq_pkg
//  Purpose : Shared types and constants for the single-level interrupt
//            sequencer (state encoding, mret opcode, default handler PC).
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package irq_pkg;

    // Sequencer states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HANDLER = 2'd1,
        ST_RESUME  = 2'd2
    } irq_state_t;

    // Full 32-bit encoding of the RV32 'mret' instruction.
    localparam logic [31:0] MRET_INST            = 32'h3020_0073;

    // Default interrupt handler entry PC.
    localparam logic [31:0] HANDLER_BASE_DEFAULT = 32'h0000_0100;

    // Default width of the taken-interrupt counter.
    localparam int          CNT_W_DEFAULT        = 16;

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module  : irq_ctrl_if
//  Purpose : Bundle between the ID stage / hazard logic and the interrupt
//            sequencer.
//  Ports   : none; signals grouped as
//            pipeline -> sequencer : interrupter, irq_en, inst_ID, PC_ID,
//                                    valid_ID, stall_ID
//            sequencer -> pipeline : trap_redirect, trap_PC, trap_flush_FD,
//                                    trap_flush_DE, epc, in_handler,
//                                    irq_pending, taken_cnt
//            modport master = pipeline side, modport slave = irq_ctrl
//  Rev     : 1.0  initial release
// ============================================================================
interface irq_ctrl_if #(
    parameter int CNT_W = 16
);

    logic              interrupter;
    logic              irq_en;
    logic [31:0]       inst_ID;
    logic [31:0]       PC_ID;
    logic              valid_ID;
    logic              stall_ID;

    logic              trap_redirect;
    logic [31:0]       trap_PC;
    logic              trap_flush_FD;
    logic              trap_flush_DE;
    logic [31:0]       epc;
    logic              in_handler;
    logic              irq_pending;
    logic [CNT_W-1:0]  taken_cnt;

    modport master (
        output interrupter, irq_en, inst_ID, PC_ID, valid_ID, stall_ID,
        input  trap_redirect, trap_PC, trap_flush_FD, trap_flush_DE,
               epc, in_handler, irq_pending, taken_cnt
    );

    modport slave (
        input  interrupter, irq_en, inst_ID, PC_ID, valid_ID, stall_ID,
        output trap_redirect, trap_PC, trap_flush_FD, trap_flush_DE,
               epc, in_handler, irq_pending, taken_cnt
    );

endinterface : irq_ctrl_if
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
//  Module  : sync_edge
//  Purpose : Two-flop synchronizer for an asynchronous level input followed
//            by a rising-edge detector. The edge pulse is one cycle wide.
//  Ports   : clk     - clock
//            rst     - synchronous active-high reset
//            i_async - raw asynchronous level
//            o_rise  - one-cycle pulse on a synchronized 0->1 transition
//  Rev     : 1.0  initial release
// ============================================================================
module sync_edge (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // r_s3 is only a delayed copy of the synchronized level, used to
    // detect the edge; it is not part of the metastability chain.
    assign o_rise = r_s2 & ~r_s3;

endmodule : sync_edge
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : irq_ctrl
//  Purpose : Single-level interrupt sequencer for the 5-stage RV32 pipeline.
//            Latches a synchronized interrupt request. At a clean ID-stage
//            issue it squashes the ID instruction, saves its PC and
//            redirects fetch to the handler. It returns to the saved PC
//            when an mret issues from ID.
//  Ports   : clk - pipeline clock
//            rst - synchronous active-high reset
//            bus - irq_ctrl_if.slave (ID-stage inputs, trap outputs, status)
//  Rev     : 1.0  initial release
// ============================================================================
module irq_ctrl
    import irq_pkg::*;
#(
    parameter logic [31:0] HANDLER_BASE = HANDLER_BASE_DEFAULT,
    parameter int          CNT_W        = CNT_W_DEFAULT
) (
    input  wire logic       clk,
    input  wire logic       rst,
    irq_ctrl_if.slave       bus
);

    irq_state_t        r_state;
    logic              r_pending;
    logic [31:0]       r_epc;
    logic [CNT_W-1:0]  r_taken_cnt;
    logic              r_in_handler;

    logic w_rise;
    logic w_issue;
    logic w_is_mret;
    logic w_take;
    logic w_ret;

    sync_edge u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.interrupter),
        .o_rise  (w_rise)
    );

    assign w_issue   = bus.valid_ID & ~bus.stall_ID;
    assign w_is_mret = (bus.inst_ID == MRET_INST);

    // Interrupts are only taken from IDLE. RESUME blocks a take until the
    // instruction at epc has issued, so every return makes progress.
    assign w_take = (r_state == ST_IDLE) & r_pending & bus.irq_en & w_issue;

    // mret only returns while in the handler; in IDLE or RESUME it
    // passes through untouched.
    assign w_ret  = (r_state == ST_HANDLER) & w_issue & w_is_mret;

    // Mealy trap outputs, OR-ed by the pipeline ahead of branch redirects.
    always_comb begin
        bus.trap_redirect = w_take | w_ret;
        bus.trap_flush_FD = w_take | w_ret;
        bus.trap_flush_DE = w_take | w_ret;
        bus.trap_PC       = HANDLER_BASE;
        if (w_ret) begin
            bus.trap_PC = r_epc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pending    <= 1'b0;
            r_epc        <= 32'h0;
            r_taken_cnt  <= '0;
            r_in_handler <= 1'b0;
        end else begin
            // A fresh edge in the same cycle as a take must not be lost:
            // set wins over clear.
            if (w_rise) begin
                r_pending <= 1'b1;
            end else if (w_take) begin
                r_pending <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        // The squashed ID instruction (possibly a branch)
                        // is re-executed after return.
                        r_epc        <= bus.PC_ID;
                        r_taken_cnt  <= r_taken_cnt + 1'b1;
                        r_state      <= ST_HANDLER;
                        r_in_handler <= 1'b1;
                    end
                end
                ST_HANDLER: begin
                    if (w_ret) begin
                        r_state      <= ST_RESUME;
                        r_in_handler <= 1'b0;
                    end
                end
                ST_RESUME: begin
                    if (w_issue) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_in_handler <= 1'b0;
                end
            endcase
        end
    end

    assign bus.epc         = r_epc;
    assign bus.in_handler  = r_in_handler;
    assign bus.irq_pending = r_pending;
    assign bus.taken_cnt   = r_taken_cnt;

endmodule : irq_ctrl
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_irq_ctrl
//  Purpose : Self-checking bench for irq_ctrl. Expected trap redirects are
//            queued by the stimulus; a negedge monitor pops one entry for
//            every cycle the DUT asserts any trap output.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_irq_ctrl;

    localparam logic [31:0] c_nop  = 32'h0000_0013;
    localparam logic [31:0] c_mret = 32'h3020_0073;
    localparam logic [31:0] c_beq  = 32'h0000_0463;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] r_exp_q[$];

    irq_ctrl_if #(.CNT_W(16)) bus ();

    irq_ctrl #(
        .HANDLER_BASE (32'h0000_0100),
        .CNT_W        (16)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle with any trap output active is one response.
    always @(negedge clk) begin
        if (bus.trap_redirect || bus.trap_flush_FD || bus.trap_flush_DE) begin
            if (r_exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_trap: got trap_PC=0x%08h expected no trap",
                         bus.trap_PC);
            end else begin
                logic [31:0] w_exp;
                w_exp = r_exp_q.pop_front();
                check("trap_PC", bus.trap_PC, w_exp);
                check("trap_ctl", {29'd0, bus.trap_redirect, bus.trap_flush_FD,
                                   bus.trap_flush_DE}, 32'd7);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.interrupter = 1'b0;
        bus.irq_en      = 1'b1;
        bus.inst_ID     = c_nop;
        bus.PC_ID       = 32'h0;
        bus.valid_ID    = 1'b1;
        bus.stall_ID    = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_epc",     bus.epc, 32'h0);
        check("rst_cnt",     {16'd0, bus.taken_cnt}, 32'h0);
        check("rst_inh",     {31'd0, bus.in_handler}, 32'h0);
        check("rst_pending", {31'd0, bus.irq_pending}, 32'h0);
        bus.PC_ID = 32'h10;
        tick();
        bus.PC_ID = 32'h14;

        // First interrupt: edge reaches pending after two more edges
        bus.interrupter = 1'b1;
        tick();
        bus.PC_ID = 32'h18;
        check("sync_k", {31'd0, bus.irq_pending}, 32'h0);
        tick();
        bus.PC_ID = 32'h1c;
        check("sync_k1", {31'd0, bus.irq_pending}, 32'h0);
        tick();
        check("sync_k2", {31'd0, bus.irq_pending}, 32'h1);
        bus.PC_ID = 32'h20;
        r_exp_q.push_back(32'h100);
        tick();
        check("take1_epc", bus.epc, 32'h20);
        check("take1_cnt", {16'd0, bus.taken_cnt}, 32'd1);
        check("take1_inh", {31'd0, bus.in_handler}, 32'h1);
        check("take1_pend", {31'd0, bus.irq_pending}, 32'h0);

        // Handler body; second request arrives but is not nested
        bus.interrupter = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.PC_ID = 32'h100 + 32'(i * 4);
            tick();
        end
        bus.interrupter = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.PC_ID = 32'h10c + 32'(i * 4);
            tick();
        end
        check("hdl_pend", {31'd0, bus.irq_pending}, 32'h1);
        check("hdl_inh",  {31'd0, bus.in_handler}, 32'h1);

        // mret returns to epc
        bus.inst_ID = c_mret;
        bus.PC_ID   = 32'h118;
        r_exp_q.push_back(32'h20);
        tick();
        check("ret_inh",  {31'd0, bus.in_handler}, 32'h0);
        check("ret_pend", {31'd0, bus.irq_pending}, 32'h1);
        bus.inst_ID  = c_nop;
        bus.valid_ID = 1'b0;
        tick();
        // RESUME: instruction at epc issues, no take yet
        bus.valid_ID = 1'b1;
        bus.PC_ID    = 32'h20;
        tick();
        check("resume_cnt", {16'd0, bus.taken_cnt}, 32'd1);
        // Back in IDLE: pending request taken now
        bus.PC_ID = 32'h24;
        r_exp_q.push_back(32'h100);
        tick();
        check("take2_epc", bus.epc, 32'h24);
        check("take2_cnt", {16'd0, bus.taken_cnt}, 32'd2);
        check("take2_inh", {31'd0, bus.in_handler}, 32'h1);

        // Leave the handler again
        bus.inst_ID = c_mret;
        bus.PC_ID   = 32'h100;
        r_exp_q.push_back(32'h24);
        tick();
        bus.inst_ID = c_nop;
        bus.PC_ID   = 32'h24;
        tick();

        // Request held off by irq_en low, then by stalls, then taken on a branch
        bus.interrupter = 1'b0;
        bus.irq_en      = 1'b0;
        bus.PC_ID       = 32'h28;
        tick();
        bus.interrupter = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.PC_ID = 32'h2c + 32'(i * 4);
            tick();
        end
        check("dis_pend", {31'd0, bus.irq_pending}, 32'h1);
        check("dis_cnt",  {16'd0, bus.taken_cnt}, 32'd2);
        bus.irq_en   = 1'b1;
        bus.stall_ID = 1'b1;
        bus.inst_ID  = c_beq;
        bus.PC_ID    = 32'h80;
        tick();
        tick();
        tick();
        check("stall_pend", {31'd0, bus.irq_pending}, 32'h1);
        check("stall_inh",  {31'd0, bus.in_handler}, 32'h0);
        bus.stall_ID = 1'b0;
        r_exp_q.push_back(32'h100);
        tick();
        check("br_epc", bus.epc, 32'h80);
        check("br_cnt", {16'd0, bus.taken_cnt}, 32'd3);
        bus.inst_ID = c_nop;

        // New request while in handler, then reset
        bus.interrupter = 1'b0;
        bus.PC_ID       = 32'h100;
        tick();
        bus.interrupter = 1'b1;
        tick();
        tick();
        tick();
        check("pre_rst_pend", {31'd0, bus.irq_pending}, 32'h1);
        check("pre_rst_inh",  {31'd0, bus.in_handler}, 32'h1);
        rst             = 1'b1;
        bus.interrupter = 1'b0;
        tick();
        rst = 1'b0;
        check("mid_rst_epc",  bus.epc, 32'h0);
        check("mid_rst_cnt",  {16'd0, bus.taken_cnt}, 32'h0);
        check("mid_rst_inh",  {31'd0, bus.in_handler}, 32'h0);
        check("mid_rst_pend", {31'd0, bus.irq_pending}, 32'h0);
        // mret after reset must not redirect
        bus.inst_ID = c_mret;
        bus.PC_ID   = 32'h104;
        tick();
        bus.inst_ID = c_nop;
        tick();
        check("post_rst_inh", {31'd0, bus.in_handler}, 32'h0);
        tick();

        check("queue_empty", 32'(r_exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_irq_ctrl
`default_nettype wire
